// File: rtl/layer3_pixel_buffer_pkg.sv
// ============================================================================
// Module   : layer3_pixel_buffer_pkg
// Purpose  : Shared constants and FSM encoding for the layer-3 pixel buffer.
// Contents : LAYER3_WEIGHT_INPUT_LENGTH (pixel word width), feature-map side
//            lengths, FILL/DONE/SERVE state encoding (2 bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package layer3_pixel_buffer_pkg;

  // 8 channels x 16 bit per pixel word
  localparam int LAYER3_WEIGHT_INPUT_LENGTH = 128;

  // Input feature-map side (must be even) and pooled side
  localparam int LAYER3_IN_DIM  = 16;
  localparam int LAYER3_OUT_DIM = LAYER3_IN_DIM / 2;

  // Buffer FSM encoding
  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] DONE  = 2'd1;
  localparam logic [1:0] SERVE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/layer3_pixel_bank.sv
// ============================================================================
// Module   : layer3_pixel_bank
// Purpose  : One parity bank of the layer-3 frame buffer: DEPTH x DATA_W
//            register file, synchronous write, registered read that loads
//            zero when the requested address is flagged invalid.
// Ports    : clk, rst        - clock, async active-high reset (read reg only)
//            wr_en_i/wr_addr_i/wr_data_i - write port
//            rd_en_i/rd_valid_i/rd_addr_i - read request, address validity
//            rd_data_o       - registered read data, holds when rd_en_i low
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer3_pixel_bank #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              rd_valid_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  // Storage is intentionally not reset: contents survive a reset as stale data.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_valid_i ? mem_q[rd_addr_i] : '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/layer3_pixel_buffer.sv
// ============================================================================
// Module   : layer3_pixel_buffer
// Purpose  : Frame buffer in front of the layer-3 2x2 max-pool. Fills one
//            IN_DIM x IN_DIM frame into four parity banks, pulses
//            pixel_store_done, then serves 2x2 windows at pooled coordinates
//            with one cycle of latency until layer3_calculation_done.
// Ports    : clk, rst (async, active high)
//            wr_en, wr_row, wr_col, wr_data, wr_ready   - fill side
//            pixel_store_done                           - frame-stored pulse
//            read_pixel_signal, read_row_addr, read_col_addr - read request
//            layer3_calculation_done                    - release to FILL
//            data_even_even/_even_odd/_odd_even/_odd_odd - window pixels
//            wr_err  - sticky dropped-write flag, only when the macro
//                      LAYER3_PIXEL_BUF_ERR_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer3_pixel_buffer
  import layer3_pixel_buffer_pkg::*;
#(
  parameter int DATA_W = LAYER3_WEIGHT_INPUT_LENGTH,
  parameter int IN_DIM = LAYER3_IN_DIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [15:0]       wr_row,
  input  logic [15:0]       wr_col,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              pixel_store_done,
  input  logic              read_pixel_signal,
  input  logic [15:0]       read_row_addr,
  input  logic [15:0]       read_col_addr,
  input  logic              layer3_calculation_done,
  output logic [DATA_W-1:0] data_even_even,
  output logic [DATA_W-1:0] data_even_odd,
  output logic [DATA_W-1:0] data_odd_even,
  output logic [DATA_W-1:0] data_odd_odd
`ifdef LAYER3_PIXEL_BUF_ERR_EN
  ,
  output logic              wr_err
`endif
);

  localparam int OUT_DIM = IN_DIM / 2;
  localparam int DEPTH   = OUT_DIM * OUT_DIM;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [15:0] c_IN_DIM  = 16'(IN_DIM);
  localparam logic [15:0] c_OUT_DIM = 16'(OUT_DIM);
  localparam logic [15:0] c_FRAME   = 16'(IN_DIM * IN_DIM);

  logic [1:0]  state_q, state_d;
  logic [15:0] count_q, count_d;

  logic          w_wr_accept;
  logic [1:0]    w_wr_bank;
  logic [AW-1:0] w_wr_addr;
  logic          w_rd_en;
  logic          w_rd_valid;
  logic [AW-1:0] w_rd_addr;
  logic          w_release;
  logic [DATA_W-1:0] w_rd_data [4];

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign w_wr_accept = wr_en && (state_q == FILL) &&
                       (wr_row < c_IN_DIM) && (wr_col < c_IN_DIM);
  // Bank index: {row parity, col parity} -> 0:ee 1:eo 2:oe 3:oo
  assign w_wr_bank   = {wr_row[0], wr_col[0]};
  assign w_wr_addr   = AW'((wr_row >> 1) * c_OUT_DIM + (wr_col >> 1));

  assign w_rd_en     = read_pixel_signal && ((state_q == DONE) || (state_q == SERVE));
  assign w_rd_valid  = (read_row_addr < c_OUT_DIM) && (read_col_addr < c_OUT_DIM);
  assign w_rd_addr   = AW'(read_row_addr * c_OUT_DIM + read_col_addr);

  assign w_release   = (state_q == SERVE) && layer3_calculation_done;

  // --------------------------------------------------------------------------
  // FSM and accepted-write counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      FILL: begin
        if (w_wr_accept) begin
          count_d = count_q + 16'd1;
          // The final write still lands this cycle; DONE follows.
          if (count_d == c_FRAME) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = SERVE;
      end
      SERVE: begin
        if (layer3_calculation_done) begin
          state_d = FILL;
          count_d = '0;
        end
      end
      default: begin
        state_d = FILL;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign wr_ready         = (state_q == FILL);
  assign pixel_store_done = (state_q == DONE);

  // --------------------------------------------------------------------------
  // Parity banks
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < 4; b++) begin : g_bank
    layer3_pixel_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (w_wr_accept && (w_wr_bank == 2'(b))),
      .wr_addr_i  (w_wr_addr),
      .wr_data_i  (wr_data),
      .rd_en_i    (w_rd_en),
      .rd_valid_i (w_rd_valid),
      .rd_addr_i  (w_rd_addr),
      .rd_data_o  (w_rd_data[b])
    );
  end

  assign data_even_even = w_rd_data[0];
  assign data_even_odd  = w_rd_data[1];
  assign data_odd_even  = w_rd_data[2];
  assign data_odd_odd   = w_rd_data[3];

  // --------------------------------------------------------------------------
  // Optional sticky dropped-write flag; releasing the buffer clears it.
  // --------------------------------------------------------------------------
`ifdef LAYER3_PIXEL_BUF_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (w_release) begin
      err_q <= 1'b0;
    end else if (wr_en && !w_wr_accept) begin
      err_q <= 1'b1;
    end
  end

  assign wr_err = err_q;
`else
  // Release only matters to the error flag; keep it referenced.
  logic w_unused_release;
  assign w_unused_release = w_release;
`endif

endmodule

`default_nettype wire
